// File: rtl/fabric_config_loader.sv
// -----------------------------------------------------------------------------
// fabric_config_loader
//
// Wishbone slave that streams configuration words into NUM_COLS column
// configuration chains. Words written to DATA are queued in a small FIFO. Each
// word is shifted out LSB first, one bit per cycle, until chain_len bits have
// been sent. The loader then pulses set_out on the selected columns and
// reloads the bit counter for the next frame.
//
// Register map (addr[3:2]):
//   0x0 DATA   (W)  push one word into the FIFO (ack stalls while full)
//   0x4 CTRL   (RW) [3:0] col_mask, [19:4] chain_len (writes ignored while busy)
//   0x8 STATUS (R)  [0] busy, [1] full, [2] empty, [5:3] count,
//                   [31:16] bits_remaining
//   0xC CRC    (R)  [15:0] CRC-16-CCITT of the shifted bits (0 when compiled out)
//
// Optional feature macro: FABRIC_CONFIG_LOADER_CRC_EN enables the CRC engine.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i Wishbone request qualifiers (sel ignored)
//   wbs_addr_i, wbs_data_i     address and write data
//   wbs_ack_o, wbs_data_o      single-cycle ack, read data (0 when no ack)
//   cen                        high while a bit is being shifted
//   shift_out[NUM_COLS]        serial bit per column, gated by col_mask
//   set_out[NUM_COLS]          one-cycle latch strobe per column
// -----------------------------------------------------------------------------
module fabric_config_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NUM_COLS   = 4,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_addr_i,
    input  logic [31:0]         wbs_data_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_data_o,
    output logic                cen,
    output logic [NUM_COLS-1:0] shift_out,
    output logic [NUM_COLS-1:0] set_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_SET   = 2'd3
    } state_t;

`ifdef FABRIC_CONFIG_LOADER_CRC_EN
    // One bit of CRC-16-CCITT (poly 0x1021), MSB-first feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic [15:0] nxt;
        nxt = {crc[14:0], 1'b0};
        if (crc[15] ^ bit_in) begin
            nxt = nxt ^ 16'h1021;
        end
        return nxt;
    endfunction
`endif

    state_t                state_r;
    state_t                state_nx_s;
    logic [31:0]           fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [3:0]            col_mask_r;
    logic [15:0]           chain_len_r;
    logic [15:0]           bits_rem_r;
    logic [31:0]           shreg_r;
    logic [4:0]            bit_idx_r;
    logic                  ack_r;
    logic [31:0]           rdata_r;
    logic                  cen_r;
    logic [NUM_COLS-1:0]   shift_r;
    logic [NUM_COLS-1:0]   set_r;
    logic [15:0]           crc_r;

    logic                  req_s;
    logic [1:0]            reg_sel_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic                  data_wr_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  ctrl_wr_s;
    logic                  busy_s;
    logic                  next_bit_s;
    logic [NUM_COLS-1:0]   col_mask_s;
    logic [2:0]            count3_s;
    logic [31:0]           status_s;
    logic [31:0]           rd_mux_s;
    logic                  unused_s;

    assign req_s        = wbs_stb_i & wbs_cyc_i & (wbs_addr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel_s    = wbs_addr_i[3:2];
    assign fifo_full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty_s = (count_r == (AW+1)'(0));
    assign pop_s        = (state_r == ST_LOAD);
    assign busy_s       = (state_r != ST_IDLE);
    // A request is serviced on the cycle before its ack; a full FIFO stalls a
    // DATA write unless an entry is being popped on that same edge.
    assign data_wr_s    = req_s & ~ack_r & wbs_we_i & (reg_sel_s == 2'd0);
    assign accept_s     = req_s & ~ack_r & (~data_wr_s | ~fifo_full_s | pop_s);
    assign push_s       = accept_s & data_wr_s;
    assign ctrl_wr_s    = accept_s & wbs_we_i & (reg_sel_s == 2'd1) & (state_r == ST_IDLE);
    assign col_mask_s   = NUM_COLS'(col_mask_r);
    assign count3_s     = 3'(count_r);
    assign status_s     = {bits_rem_r, 10'd0, count3_s, fifo_empty_s, fifo_full_s, busy_s};
    assign unused_s     = ^{wbs_sel_i, wbs_addr_i[1:0], wbs_data_i[31:20]};

    // Next-state logic of the load/shift/set sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && (bits_rem_r != 16'd0)) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nx_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Chain completion wins over word completion: leftover bits are dropped.
                if (bits_rem_r == 16'd1) begin
                    state_nx_s = ST_SET;
                end else if (bit_idx_r == 5'd31) begin
                    if (!fifo_empty_s) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_SET: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Bit that will be on shift_out during the next cycle, so the serial
    // outputs can be registered yet stay aligned with the SHIFT state.
    always_comb begin
        next_bit_s = 1'b0;
        if (state_nx_s == ST_SHIFT) begin
            if (state_r == ST_LOAD) begin
                next_bit_s = fifo_mem_r[rd_ptr_r][0];
            end else begin
                next_bit_s = shreg_r[1];
            end
        end else begin
            next_bit_s = 1'b0;
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = 32'd0;
        case (reg_sel_s)
            2'd0: rd_mux_s = 32'd0;
            2'd1: rd_mux_s = {12'd0, chain_len_r, col_mask_r};
            2'd2: rd_mux_s = status_s;
`ifdef FABRIC_CONFIG_LOADER_CRC_EN
            2'd3: rd_mux_s = {16'd0, crc_r};
`else
            2'd3: rd_mux_s = 32'd0;
`endif
            default: rd_mux_s = 32'd0;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wbs_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer state, configuration registers and shift datapath.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_IDLE;
            col_mask_r  <= 4'd0;
            chain_len_r <= 16'd0;
            bits_rem_r  <= 16'd0;
            shreg_r     <= 32'd0;
            bit_idx_r   <= 5'd0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_wr_s) begin
                        col_mask_r  <= wbs_data_i[3:0];
                        chain_len_r <= wbs_data_i[19:4];
                        bits_rem_r  <= wbs_data_i[19:4];
                    end
                end
                ST_LOAD: begin
                    shreg_r   <= fifo_mem_r[rd_ptr_r];
                    bit_idx_r <= 5'd0;
                end
                ST_SHIFT: begin
                    shreg_r    <= {1'b0, shreg_r[31:1]};
                    bit_idx_r  <= bit_idx_r + 5'd1;
                    bits_rem_r <= bits_rem_r - 16'd1;
                end
                ST_SET: begin
                    bits_rem_r <= chain_len_r;
                end
                default: begin
                    bits_rem_r <= bits_rem_r;
                end
            endcase
        end
    end

    // Registered column outputs, computed from the upcoming state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cen_r   <= 1'b0;
            shift_r <= '0;
            set_r   <= '0;
        end else begin
            cen_r   <= (state_nx_s == ST_SHIFT);
            shift_r <= {NUM_COLS{next_bit_s}} & col_mask_s;
            set_r   <= (state_nx_s == ST_SET) ? col_mask_s : '0;
        end
    end

    // Wishbone ack and read data; data is forced to zero outside the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r   <= accept_s;
            rdata_r <= (accept_s & ~wbs_we_i) ? rd_mux_s : 32'd0;
        end
    end

`ifdef FABRIC_CONFIG_LOADER_CRC_EN
    // CRC over every shifted bit, restarted by each accepted CTRL write.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            crc_r <= 16'd0;
        end else if (ctrl_wr_s) begin
            crc_r <= 16'hFFFF;
        end else if (state_r == ST_SHIFT) begin
            crc_r <= crc16_step(crc_r, shreg_r[0]);
        end
    end
`else
    assign crc_r = 16'd0;
`endif

    assign wbs_ack_o  = ack_r;
    assign wbs_data_o = rdata_r;
    assign cen        = cen_r;
    assign shift_out  = shift_r;
    assign set_out    = set_r;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Scoreboard bench for fabric_config_loader. A high-level model turns each
// CTRL/DATA write into the expected list of shifted column values and set
// strobes; a monitor pops that list whenever cen or set_out is seen, and pops a
// read-data queue whenever wbs_ack_o is seen.
module tb_fabric_config_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ack;
    logic [31:0] rdata;
    logic        cen;
    logic [3:0]  shift_out, set_out;

    always #5 clk = ~clk;

    fabric_config_loader #(.BASE_ADDR(BASE), .NUM_COLS(4), .FIFO_DEPTH(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_addr_i(addr), .wbs_data_i(wdata),
        .wbs_ack_o(ack), .wbs_data_o(rdata),
        .cen(cen), .shift_out(shift_out), .set_out(set_out)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { bit is_set; logic [3:0] val; } ev_t;
    ev_t         exp_q[$];
    logic [31:0] ack_q[$];
    int          shift_seen = 0;
    ev_t         mon_e;

    // Reference model state
    int unsigned m_chain = 0, m_rem = 0;
    logic [3:0]  m_mask = 4'd0;
    logic [15:0] m_crc = 16'd0;
    logic [31:0] m_words[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    // Consume queued words while a frame is open, emitting expected events.
    function automatic void model_run();
        logic [31:0] w;
        ev_t e;
        while (m_rem != 0 && m_words.size() > 0) begin
            w = m_words.pop_front();
            for (int i = 0; i < 32 && m_rem != 0; i++) begin
                e.is_set = 1'b0;
                e.val = {4{w[i]}} & m_mask;
                exp_q.push_back(e);
                m_crc = crc_step(m_crc, w[i]);
                m_rem--;
            end
            if (m_rem == 0) begin
                e.is_set = 1'b1;
                e.val = m_mask;
                exp_q.push_back(e);
                m_rem = m_chain;
            end
        end
    endfunction

    function automatic logic [31:0] exp_status();
        return {m_rem[15:0], 16'h0004};
    endfunction

    function automatic logic [31:0] exp_crc();
`ifdef FABRIC_CONFIG_LOADER_CRC_EN
        return {16'd0, m_crc};
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: compare every DUT presentation against the scoreboards.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack) begin
                if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else chk("wb_rdata", rdata, ack_q.pop_front());
            end else begin
                chk("rdata_idle", rdata, 32'd0);
            end
            if (cen) begin
                shift_seen++;
                if (exp_q.size() == 0) chk("unexpected_cen", 32'd1, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("shift_kind", {31'd0, mon_e.is_set}, 32'd0);
                    chk("shift_out", {28'd0, shift_out}, {28'd0, mon_e.val});
                    chk("set_during_shift", {28'd0, set_out}, 32'd0);
                end
            end else if (set_out != 4'd0) begin
                if (exp_q.size() == 0) chk("unexpected_set", {28'd0, set_out}, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("set_kind", {31'd0, mon_e.is_set}, 32'd1);
                    chk("set_out", {28'd0, set_out}, {28'd0, mon_e.val});
                end
            end
        end
    end

    // One Wishbone transfer; the expected read word is queued before driving.
    task automatic wb(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [31:0] exp_rd);
        int n;
        @(posedge clk); #1;
        ack_q.push_back(w ? 32'd0 : exp_rd);
        stb = 1'b1; cyc = 1'b1; we = w; addr = a; wdata = d; sel = 4'($urandom);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (ack) break;
            n++;
        end
        if (n >= 200) begin
            chk("ack_timeout", 32'd0, 32'd1);
            void'(ack_q.pop_back());
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [3:0] mask, input logic [15:0] len);
        m_mask = mask; m_chain = len; m_rem = len; m_crc = 16'hFFFF;
        model_run();
        wb(BASE + 32'h4, 1'b1, {12'd0, len, mask}, 32'd0);
    endtask

    task automatic data_wr(input logic [31:0] d);
        m_words.push_back(d);
        model_run();
        wb(BASE + 32'h0, 1'b1, d, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic model_reset();
        m_chain = 0; m_rem = 0; m_mask = 4'd0; m_crc = 16'd0;
        m_words.delete();
        exp_q.delete();
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_cen"}, {31'd0, cen}, 32'd0);
        chk({tag, "_shift"}, {28'd0, shift_out}, 32'd0);
        chk({tag, "_set"}, {28'd0, set_out}, 32'd0);
    endtask

    initial begin
        int n;
        int base_seen;
        logic [3:0] rmask;
        logic [15:0] rlen;
        int nw;

        repeat (3) @(posedge clk);
        #1 outputs_zero("reset");
        rst_n = 1'b1;

        // Reset state of the register file
        wb(BASE + 32'h8, 1'b0, 32'd0, 32'h0000_0004);
        wb(BASE + 32'h4, 1'b0, 32'd0, 32'd0);
        wb(BASE + 32'hC, 1'b0, 32'd0, 32'd0);

        // chain_len==0: word stays queued, nothing shifts
        data_wr(32'h1234_5678);
        repeat (10) @(negedge clk);
        wb(BASE + 32'h8, 1'b0, 32'd0, 32'h0000_0008);

        // mask F, chain 32 (queued word goes first), then A5A5A5A5
        ctrl_wr(4'hF, 16'd32);
        data_wr(32'hA5A5_A5A5);
        drain();
        wb(BASE + 32'h8, 1'b0, 32'd0, exp_status());

        // mask 0101, chain 8: 24 bits of the word discarded
        ctrl_wr(4'b0101, 16'd8);
        data_wr(32'hFFFF_FFFF);
        drain();
        wb(BASE + 32'h8, 1'b0, 32'd0, exp_status());

        // CRC of 32 zero bits
        ctrl_wr(4'hF, 16'd32);
        data_wr(32'h0000_0000);
        drain();
        wb(BASE + 32'hC, 1'b0, 32'd0, exp_crc());

        // chain 64 with six back-to-back words (FIFO fills, ack stalls)
        ctrl_wr(4'hF, 16'd64);
        for (int i = 0; i < 6; i++) data_wr($urandom);
        drain();
        wb(BASE + 32'h8, 1'b0, 32'd0, exp_status());
        wb(BASE + 32'hC, 1'b0, 32'd0, exp_crc());

        // Randomized frames
        for (int it = 0; it < 6; it++) begin
            rmask = 4'($urandom_range(1, 15));
            rlen  = 16'($urandom_range(1, 100));
            nw    = $urandom_range(1, 6);
            ctrl_wr(rmask, rlen);
            wb(BASE + 32'h4, 1'b0, 32'd0, {12'd0, rlen, rmask});
            for (int k = 0; k < nw; k++) data_wr($urandom);
            drain();
            wb(BASE + 32'h8, 1'b0, 32'd0, exp_status());
            wb(BASE + 32'hC, 1'b0, 32'd0, exp_crc());
        end

        // CTRL write while busy is acked but ignored
        ctrl_wr(4'hF, 16'd32);
        base_seen = shift_seen;
        data_wr($urandom);
        n = 0;
        while (shift_seen < base_seen + 2 && n < 100) begin @(negedge clk); n++; end
        wb(BASE + 32'h4, 1'b1, {12'd0, 16'd8, 4'b0101}, 32'd0);
        wb(BASE + 32'h4, 1'b0, 32'd0, {12'd0, 16'd32, 4'hF});
        drain();

        // Reset in the middle of SHIFT
        ctrl_wr(4'hF, 16'd32);
        base_seen = shift_seen;
        data_wr($urandom);
        n = 0;
        while (shift_seen < base_seen + 10 && n < 200) begin @(negedge clk); n++; end
        chk("shift_started", {31'd0, (shift_seen >= base_seen + 10)}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1 outputs_zero("midshift_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        wb(BASE + 32'h8, 1'b0, 32'd0, 32'h0000_0004);
        wb(BASE + 32'hC, 1'b0, 32'd0, 32'd0);

        // Read outside the base window: no ack, data stays 0
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; addr = 32'h4000_0008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("nodecode_ack", {31'd0, ack}, 32'd0);
            chk("nodecode_data", rdata, 32'd0);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        repeat (3) @(negedge clk);
        chk("ack_q_empty", ack_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
